// File: rtl/vx_rr_grant_arbiter_if.sv
// vx_rr_grant_arbiter_if: request/grant bundle between requesters and the arbiter.
// slave = arbiter side, master = requester/consumer side.
interface vx_rr_grant_arbiter_if #(
  parameter int N  = 4,
  parameter int LN = (N > 1) ? $clog2(N) : 1
);
  logic [N-1:0]  requests;
  logic [N-1:0]  grant_onehot;
  logic [LN-1:0] grant_index;
  logic          grant_valid;
  logic          grant_ready;

  modport slave (
    input  requests,
    input  grant_ready,
    output grant_onehot,
    output grant_index,
    output grant_valid
  );

  modport master (
    output requests,
    output grant_ready,
    input  grant_onehot,
    input  grant_index,
    input  grant_valid
  );
endinterface

// File: rtl/vx_rr_grant_arbiter.sv
// vx_rr_grant_arbiter: round-robin arbiter, one-hot grant plus binary index.
// Define VX_RR_ARB_STICKY_EN to pin a stalled grant until it fires.
module vx_rr_grant_arbiter #(
  parameter int N  = 4,
  parameter int LN = (N > 1) ? $clog2(N) : 1
) (
  input logic                  clk,
  input logic                  reset,
  vx_rr_grant_arbiter_if.slave arb
);

  logic [LN-1:0] ptr_q;
  logic [LN-1:0] ptr_d;
  logic [LN-1:0] rr_idx;
  logic          rr_found;
  logic [LN-1:0] win_idx;
  logic          win_found;
  logic [N-1:0]  oh;
  logic          fire;
  int            k;

  // Scan from ptr upward, wrapping at N, first hit wins.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    k        = 0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr_q) + i;
      if (k >= N) k = k - N;
      if (!rr_found && arb.requests[k]) begin
        rr_found = 1'b1;
        rr_idx   = LN'(k);
      end
    end
  end

`ifdef VX_RR_ARB_STICKY_EN
  logic          lock_valid_q;
  logic          lock_valid_d;
  logic [LN-1:0] lock_index_q;
  logic [LN-1:0] lock_index_d;
  logic          lock_hit;

  assign lock_hit  = lock_valid_q
                   & arb.requests[lock_index_q];
  assign win_found = lock_hit | rr_found;
  assign win_idx   = lock_hit ? lock_index_q
                              : rr_idx;

  // Recapturing every stalled cycle also covers
  // a dropped lock that re-stalls on a new winner.
  assign lock_valid_d = arb.grant_valid
                      & ~arb.grant_ready;
  assign lock_index_d = arb.grant_index;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_valid_q <= 1'b0;
      lock_index_q <= '0;
    end else begin
      lock_valid_q <= lock_valid_d;
      lock_index_q <= lock_index_d;
    end
  end
`else
  assign win_found = rr_found;
  assign win_idx   = rr_idx;
`endif

  assign arb.grant_valid = win_found & ~reset;
  assign arb.grant_index = arb.grant_valid
                         ? win_idx : '0;

  always_comb begin
    oh = '0;
    if (arb.grant_valid) oh[win_idx] = 1'b1;
  end

  assign arb.grant_onehot = oh;

  assign fire = arb.grant_valid & arb.grant_ready;

  always_comb begin
    ptr_d = ptr_q;
    if (fire) begin
      if (win_idx == LN'(N - 1)) ptr_d = '0;
      else ptr_d = win_idx + LN'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else ptr_q <= ptr_d;
  end

endmodule

// File: tb/tb_vx_rr_grant_arbiter.sv
// tb_vx_rr_grant_arbiter: directed checks on N=4 and N=5 arbiters.
// Expected sticky behaviour follows VX_RR_ARB_STICKY_EN.
module tb_vx_rr_grant_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  vx_rr_grant_arbiter_if #(.N(4)) a_if ();
  vx_rr_grant_arbiter_if #(.N(5)) b_if ();

  vx_rr_grant_arbiter #(.N(4)) u4 (
    .clk  (clk),
    .reset(reset),
    .arb  (a_if.slave)
  );

  vx_rr_grant_arbiter #(.N(5)) u5 (
    .clk  (clk),
    .reset(reset),
    .arb  (b_if.slave)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // idx < 0 means no grant expected
  task automatic exp4(input string tag, input int idx);
    if (idx < 0) begin
      check({tag, ".v"}, 32'(a_if.grant_valid), 0);
      check({tag, ".oh"}, 32'(a_if.grant_onehot), 0);
      check({tag, ".ix"}, 32'(a_if.grant_index), 0);
    end else begin
      check({tag, ".v"}, 32'(a_if.grant_valid), 1);
      check({tag, ".oh"}, 32'(a_if.grant_onehot),
            32'(1) << idx);
      check({tag, ".ix"}, 32'(a_if.grant_index),
            32'(idx));
    end
  endtask

  task automatic exp5(input string tag, input int idx);
    check({tag, ".v"}, 32'(b_if.grant_valid), 1);
    check({tag, ".oh"}, 32'(b_if.grant_onehot),
          32'(1) << idx);
    check({tag, ".ix"}, 32'(b_if.grant_index),
          32'(idx));
  endtask

  task automatic drv4(input logic [3:0] r,
                      input logic rdy);
    @(negedge clk);
    a_if.requests    = r;
    a_if.grant_ready = rdy;
    #1;
  endtask

  task automatic drv5(input logic [4:0] r,
                      input logic rdy);
    @(negedge clk);
    b_if.requests    = r;
    b_if.grant_ready = rdy;
    #1;
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    reset            = 1'b1;
    a_if.requests    = '0;
    a_if.grant_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset            = 1'b1;
    a_if.requests    = 4'b1111;
    a_if.grant_ready = 1'b1;
    b_if.requests    = '0;
    b_if.grant_ready = 1'b0;
    #1;
    exp4("rst", -1);
    a_if.requests    = '0;
    a_if.grant_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // full load rotates 0,1,2,3
    for (int i = 0; i < 8; i++) begin
      drv4(4'b1111, 1'b1);
      exp4($sformatf("all%0d", i), i % 4);
    end

    // sparse pattern wraps 3 -> 0
    drv4(4'b1010, 1'b1); exp4("sp0", 1);
    drv4(4'b1010, 1'b1); exp4("sp1", 3);
    drv4(4'b1010, 1'b1); exp4("sp2", 1);

    // stall holds grant, fire moves ptr to 3
    rst_pulse();
    for (int i = 0; i < 3; i++) begin
      drv4(4'b0100, 1'b0);
      exp4($sformatf("stl%0d", i), 2);
    end
    drv4(4'b0100, 1'b1); exp4("stlf", 2);
    drv4(4'b1111, 1'b0); exp4("ptr3", 3);

    // new requests during a stall
    rst_pulse();
    drv4(4'b0100, 1'b0); exp4("stk0", 2);
    drv4(4'b0111, 1'b0);
`ifdef VX_RR_ARB_STICKY_EN
    exp4("stk1", 2);
`else
    exp4("stk1", 0);
`endif

    // async reset mid-stall
    rst_pulse();
    drv4(4'b1000, 1'b0); exp4("ms0", 3);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 exp4("msr", -1);
    @(negedge clk);
    reset = 1'b0;
    #1 exp4("msrel", 3);

    // requests vanish while stalled, ready alone is inert
    drv4(4'b0100, 1'b0); exp4("dr0", 2);
    drv4(4'b0000, 1'b0); exp4("dr1", -1);
    drv4(4'b0000, 1'b1); exp4("dr2", -1);
    drv4(4'b0011, 1'b1); exp4("dr3", 0);

    // N=5 wraps from 4 to 0
    drv5(5'b10001, 1'b1); exp5("n5a", 0);
    drv5(5'b10001, 1'b1); exp5("n5b", 4);
    drv5(5'b10001, 1'b1); exp5("n5c", 0);
    drv5(5'b11111, 1'b0); exp5("n5d", 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
